// File: rtl/text_sequencer.sv
// text_sequencer: reveals one of eight fixed-length on-screen messages
// one character per CHAR_TICKS cycles, holds it for HOLD_TICKS cycles,
// then raises textFin until the controller asserts rstText.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rstText    synchronous clear / idle request from the game controller
//   textSel    message select, latched when leaving IDLE
//   pause      freezes tick counting while high
//   skip       one-cycle pulse, fast-forwards REVEAL -> HOLD -> DONE
//   textFin    message fully shown and hold elapsed (level)
//   visCount   characters currently revealed, 0..16
//   curSel     latched message select
//   romAddr    {curSel, visCount[3:0]}, next character to reveal
//   charStrobe one-cycle pulse per character reveal
module text_sequencer #(
    parameter int CHAR_TICKS = 5000000,
    parameter int HOLD_TICKS = 100000000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstText,
    input  logic [2:0] textSel,
    input  logic       pause,
    input  logic       skip,
    output logic       textFin,
    output logic [4:0] visCount,
    output logic [2:0] curSel,
    output logic [6:0] romAddr,
    output logic       charStrobe
);

    typedef enum logic [1:0] {
        IDLE,
        REVEAL,
        HOLD,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

    function automatic logic [4:0] msg_len(input logic [2:0] sel);
        logic [4:0] len;
        case (sel)
            3'd0:    len = 5'd0;
            3'd1:    len = 5'd16;
            3'd2:    len = 5'd9;
            3'd3:    len = 5'd10;
            3'd4:    len = 5'd8;
            3'd5:    len = 5'd14;
            3'd6:    len = 5'd9;
            default: len = 5'd12;
        endcase
        return len;
    endfunction

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] tick;
    logic [CNT_W-1:0] tick_n;
    logic [4:0]       vis_n;
    logic [2:0]       sel_n;
    logic             fin_n;
    logic             strobe_n;

    logic [4:0] len_cur;
    logic [4:0] len_new;
    logic [4:0] vis_inc;
    logic       char_last;
    logic       hold_last;

    assign len_cur   = msg_len(curSel);
    assign len_new   = msg_len(textSel);
    assign vis_inc   = visCount + 5'd1;
    assign char_last = (tick == CHAR_LAST);
    assign hold_last = (tick == HOLD_LAST);

    // State register plus all registered outputs and the tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            visCount   <= '0;
            curSel     <= '0;
            textFin    <= 1'b0;
            charStrobe <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            visCount   <= vis_n;
            curSel     <= sel_n;
            textFin    <= fin_n;
            charStrobe <= strobe_n;
        end
    end

    // Next-state logic. Priority: rstText, then skip, then pause.
    always_comb begin
        state_n = state;
        if (rstText) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n = (len_new == 5'd0) ? HOLD : REVEAL;
                end
                REVEAL: begin
                    if (skip)
                        state_n = HOLD;
                    else if (!pause && char_last && vis_inc == len_cur)
                        state_n = HOLD;
                end
                HOLD: begin
                    if (skip)
                        state_n = DONE;
                    else if (!pause && hold_last)
                        state_n = DONE;
                end
                default: state_n = DONE;
            endcase
        end
    end

    // Next values of the registered outputs and tick counter.
    always_comb begin
        tick_n   = tick;
        vis_n    = visCount;
        sel_n    = curSel;
        fin_n    = textFin;
        strobe_n = 1'b0;
        if (rstText) begin
            tick_n = '0;
            vis_n  = '0;
            fin_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sel_n  = textSel;
                    tick_n = '0;
                    vis_n  = '0;
                    fin_n  = 1'b0;
                end
                REVEAL: begin
                    if (skip) begin
                        // Skip beats a coincident reveal and emits no strobe.
                        vis_n  = len_cur;
                        tick_n = '0;
                    end else if (!pause) begin
                        if (char_last) begin
                            tick_n   = '0;
                            vis_n    = vis_inc;
                            strobe_n = 1'b1;
                        end else begin
                            tick_n = tick + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (skip) begin
                        fin_n = 1'b1;
                    end else if (!pause) begin
                        if (hold_last) begin
                            fin_n  = 1'b1;
                            tick_n = '0;
                        end else begin
                            tick_n = tick + 1'b1;
                        end
                    end
                end
                default: begin
                    fin_n = 1'b1;
                    vis_n = len_cur;
                end
            endcase
        end
    end

    // Only the low nibble addresses the ROM; a full 16-char message
    // wraps to 0 there, but no further reveal ever uses it.
    always_comb begin
        romAddr = {curSel, visCount[3:0]};
    end

endmodule

// File: tb/tb_text_sequencer.sv
// tb_text_sequencer: directed bench for text_sequencer with
// CHAR_TICKS=4, HOLD_TICKS=8.
module tb_text_sequencer;

    localparam int CT = 4;
    localparam int HT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rstText;
    logic [2:0] textSel;
    logic       pause;
    logic       skip;
    logic       textFin;
    logic [4:0] visCount;
    logic [2:0] curSel;
    logic [6:0] romAddr;
    logic       charStrobe;

    int total = 0;
    int bad   = 0;

    text_sequencer #(
        .CHAR_TICKS(CT),
        .HOLD_TICKS(HT),
        .CNT_W(27)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rstText(rstText),
        .textSel(textSel),
        .pause(pause),
        .skip(skip),
        .textFin(textFin),
        .visCount(visCount),
        .curSel(curSel),
        .romAddr(romAddr),
        .charStrobe(charStrobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        int         len;
        logic [6:0] addr;
        logic       fin;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int cyc,
                         input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int t_rev(input int k, input int r, input int p);
        return 1 + CT * k + ((p > 0 && k > r) ? p : 0);
    endfunction

    // Play one message from an rstText drop; pause is held for p cycles
    // right after reveal number r (p=0 means no pause).
    task automatic play(input logic [2:0] sel, input int len,
                        input int r, input int p, input int n);
        int tf;
        int es;
        int ev;
        rstText = 1'b1;
        step();
        step();
        textSel = sel;
        rstText = 1'b0;
        tf = 1 + CT * len + HT + ((p > 0 && r < len) ? p : 0);
        for (int c = 1; c <= n; c++) begin
            pause = (p > 0 && c > t_rev(r, r, p) && c <= t_rev(r, r, p) + p);
            step();
            es = 0;
            ev = 0;
            for (int k = 1; k <= len; k++) begin
                if (t_rev(k, r, p) == c) es = 1;
                if (t_rev(k, r, p) <= c) ev++;
            end
            check("strobe", c, int'(charStrobe), es);
            check("fin", c, int'(textFin), int'(c >= tf));
            check("vis", c, int'(visCount), ev);
            check("addr", c, int'(romAddr), int'({sel, 4'(ev)}));
        end
        pause = 1'b0;
        check("cursel", n, int'(curSel), int'(sel));
    endtask

    initial begin
        rst     = 1'b1;
        rstText = 1'b1;
        textSel = 3'd0;
        pause   = 1'b0;
        skip    = 1'b0;

        vecs[0] = '{3'd0, 0,  7'h00, 1'b1};
        vecs[1] = '{3'd1, 16, 7'h10, 1'b0};
        vecs[2] = '{3'd2, 9,  7'h29, 1'b0};
        vecs[3] = '{3'd3, 10, 7'h3A, 1'b0};
        vecs[4] = '{3'd4, 8,  7'h48, 1'b0};
        vecs[5] = '{3'd5, 14, 7'h5E, 1'b0};
        vecs[6] = '{3'd6, 9,  7'h69, 1'b0};
        vecs[7] = '{3'd7, 12, 7'h7C, 1'b0};

        // Reset, then idle with rstText high.
        step();
        step();
        check("rst_fin", 0, int'(textFin), 0);
        check("rst_vis", 0, int'(visCount), 0);
        check("rst_sel", 0, int'(curSel), 0);
        check("rst_strobe", 0, int'(charStrobe), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("idle_fin", 10, int'(textFin), 0);
        check("idle_vis", 10, int'(visCount), 0);
        check("idle_addr", 10, int'(romAddr), 0);
        check("idle_strobe", 10, int'(charStrobe), 0);

        // Length table via skip: latch, skip once, then skip again.
        for (int i = 0; i < 8; i++) begin
            rstText = 1'b1;
            step();
            textSel = vecs[i].sel;
            rstText = 1'b0;
            step();
            check("tbl_sel", i, int'(curSel), int'(vecs[i].sel));
            check("tbl_addr0", i, int'(romAddr), int'({vecs[i].sel, 4'd0}));
            skip = 1'b1;
            step();
            skip = 1'b0;
            check("tbl_vis", i, int'(visCount), vecs[i].len);
            check("tbl_addr", i, int'(romAddr), int'(vecs[i].addr));
            check("tbl_strobe", i, int'(charStrobe), 0);
            check("tbl_fin", i, int'(textFin), int'(vecs[i].fin));
            skip = 1'b1;
            step();
            skip = 1'b0;
            check("tbl_fin2", i, int'(textFin), 1);
            check("tbl_vis2", i, int'(visCount), vecs[i].len);
        end

        // Plain playback, paused playback, empty message.
        play(3'd2, 9, 0, 0, 65);
        play(3'd1, 16, 3, 10, 90);
        play(3'd0, 0, 0, 0, 20);

        // Skip after two reveals, then skip in HOLD.
        rstText = 1'b1;
        step();
        textSel = 3'd7;
        rstText = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("sk_vis2", 9, int'(visCount), 2);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("sk_vis", 10, int'(visCount), 12);
        check("sk_strobe", 10, int'(charStrobe), 0);
        check("sk_fin", 10, int'(textFin), 0);
        step();
        check("sk_hold", 11, int'(textFin), 0);
        check("sk_strobe2", 11, int'(charStrobe), 0);
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("sk_done", 12, int'(textFin), 1);
        check("sk_vis3", 12, int'(visCount), 12);
        skip  = 1'b1;
        pause = 1'b1;
        step();
        skip  = 1'b0;
        step();
        pause = 1'b0;
        check("done_fin", 14, int'(textFin), 1);
        check("done_vis", 14, int'(visCount), 12);
        for (int i = 0; i < 5; i++) step();
        check("done_hold", 19, int'(textFin), 1);

        // rstText mid-REVEAL with a new select, then restart.
        rstText = 1'b1;
        step();
        textSel = 3'd1;
        rstText = 1'b0;
        for (int i = 0; i < 21; i++) step();
        check("mid_vis", 21, int'(visCount), 5);
        textSel = 3'd4;
        rstText = 1'b1;
        step();
        check("mid_clr_vis", 22, int'(visCount), 0);
        check("mid_clr_fin", 22, int'(textFin), 0);
        check("mid_clr_strobe", 22, int'(charStrobe), 0);
        check("mid_keep_sel", 22, int'(curSel), 1);
        play(3'd4, 8, 0, 0, 45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
